// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

    typedef enum logic [1:0] {
        FQ_IDLE    = 2'd0,
        FQ_REQ     = 2'd1,
        FQ_DISCARD = 2'd2
    } fq_state_e;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]       pc4;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// Synchronous FIFO with clear; read data is the head entry decoded from registered state.
module fifo_sync #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; empty entries are never observed downstream.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, issues one req/ack read at a time,
// buffers {pc+4, inst} for decode and flushes on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       out_pc4,
    input  logic              out_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_e         state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       fetch_pc_d;
    logic [31:0]       pc_inc;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              empty;
    fq_entry_t         wr_entry;
    fq_entry_t         head;
    logic              unused_pc_lo;

    assign unused_pc_lo = ^redirect_pc[1:0];
    assign pc_inc       = fetch_pc_q + 32'd4;

    always_comb begin
        push       = (state_q == FQ_REQ) && mem_ack && !redirect;
        pop        = !empty && out_ready && !redirect;
        count_next = count + CW'(push) - CW'(pop);
        fetch_pc_d = fetch_pc_q;
        if (redirect)  fetch_pc_d = {redirect_pc[31:2], 2'b00};
        else if (push) fetch_pc_d = pc_inc;
        wr_entry.pc4  = pc_inc;
        wr_entry.inst = mem_rdata;
    end

    // Reserve rule: a request is only ever outstanding while the FIFO has room,
    // so an ack can always be pushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FQ_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                FQ_IDLE: begin
                    if (!redirect && !full) begin
                        state_q    <= FQ_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                FQ_REQ: begin
                    if (redirect) begin
                        if (mem_ack) begin
                            state_q   <= FQ_IDLE;
                            mem_req_q <= 1'b0;
                        end else begin
                            state_q <= FQ_DISCARD;
                        end
                    end else if (mem_ack) begin
                        if (count_next < CW'(DEPTH)) begin
                            mem_addr_q <= pc_inc;
                        end else begin
                            state_q   <= FQ_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                FQ_DISCARD: begin
                    if (mem_ack) begin
                        state_q   <= FQ_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= FQ_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fifo_sync #(
        .WIDTH($bits(fq_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (redirect),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = !empty;
    assign out_inst  = empty ? NOP_WORD : head.inst;
    assign out_pc4   = empty ? 32'h0 : head.pc4;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based model, plus directed scenarios.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc4;
    logic        out_ready = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    bit          chk_en = 1'b0;

    // memory behaviour
    bit          mem_busy = 1'b0;
    int unsigned mem_wait = 0;
    int unsigned wait_min = 0;
    int unsigned wait_max = 0;

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc = '0;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    logic [31:0] m_addr = '0;

    fetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_pc4    (out_pc4),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: advance one clock using the inputs held across the edge.
    always @(posedge clk) begin
        int unsigned sz;
        bit          pop;
        bit          push;
        logic [31:0] pc_old;
        if (!rst_n) begin
            mq.delete();
            m_pc    = 32'h0;
            m_out   = 1'b0;
            m_stale = 1'b0;
            m_addr  = 32'h0;
        end else begin
            sz     = mq.size();
            pc_old = m_pc;
            pop    = (sz > 0) && out_ready && !redirect;
            push   = m_out && !m_stale && mem_ack && !redirect;
            if (!m_out) begin
                if (!redirect && sz < DEPTH) begin
                    m_out = 1'b1; m_stale = 1'b0; m_addr = pc_old;
                end
            end else if (m_stale) begin
                if (mem_ack) m_out = 1'b0;
            end else if (redirect) begin
                if (mem_ack) m_out = 1'b0;
                else         m_stale = 1'b1;
            end else if (mem_ack) begin
                if (sz + 1 - int'(pop) < DEPTH) m_addr = pc_old + 32'd4;
                else                            m_out = 1'b0;
            end
            if (redirect) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back({pc_old + 32'd4, mem_rdata});
                    m_pc = pc_old + 32'd4;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", 32'(mem_req), 32'(m_out));
            if (m_out) check("mem_addr", mem_addr, m_addr);
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("out_inst", out_inst, mq[0][31:0]);
                check("out_pc4", out_pc4, mq[0][63:32]);
            end else begin
                check("out_inst_empty", out_inst, 32'h0);
                check("out_pc4_empty", out_pc4, 32'h0);
            end
        end
    end

    // Called at a falling edge: drive inputs for the next rising edge, then wait one cycle.
    task automatic tick(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
        rst_n       = r;
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = rdy;
        mem_rdata   = $urandom;
        if (!r || !mem_req) begin
            mem_busy = 1'b0;
            mem_ack  = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(wait_max, wait_min);
            end
            if (mem_wait == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = word_at(mem_addr);
                mem_busy  = 1'b0;
            end else begin
                mem_ack  = 1'b0;
                mem_wait = mem_wait - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_addr(input string name, input logic [31:0] addr, input logic rdy,
                             input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!(mem_req && mem_addr == addr) && n < limit) begin
            tick(1'b1, 1'b0, 32'h0, rdy);
            n++;
        end
        check({name, "_req"}, 32'(mem_req), 32'h1);
        check({name, "_addr"}, mem_addr, addr);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] exp_pc4;

        // zero-wait memory streaming
        @(negedge clk);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        wait_min = 0; wait_max = 0;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_req", 32'(mem_req), 32'h1);
        check("t1_addr0", mem_addr, 32'h0);
        check("t1_valid0", 32'(out_valid), 32'h0);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_valid1", 32'(out_valid), 32'h1);
        check("t1_inst0", out_inst, 32'hDEAD_BEEF);
        check("t1_pc4_0", out_pc4, 32'h4);
        check("t1_addr4", mem_addr, 32'h4);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            check("t1_stream_pc4", out_pc4, 32'(8 + 4 * k));
            check("t1_stream_valid", 32'(out_valid), 32'h1);
        end

        // back-pressure fills exactly DEPTH entries
        do_reset();
        wait_min = 2; wait_max = 2;
        for (int k = 0; k < 30; k++) tick(1'b1, 1'b0, 32'h0, 1'b0);
        check("t2_req_off", 32'(mem_req), 32'h0);
        check("t2_model_count", mq.size(), 32'(DEPTH));
        check("t2_head_pc4", out_pc4, 32'h4);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        wait_addr("t2_reissue", 32'h10, 1'b0, 5);

        // redirect while a request is outstanding
        do_reset();
        wait_min = 3; wait_max = 3;
        wait_addr("t3_at8", 32'h8, 1'b1, 20);
        tick(1'b1, 1'b1, 32'h40, 1'b1);
        check("t3_flush", 32'(out_valid), 32'h0);
        check("t3_hold_addr", mem_addr, 32'h8);
        wait_addr("t3_new", 32'h40, 1'b1, 10);
        n = 0;
        while (!out_valid && n < 10) begin tick(1'b1, 1'b0, 32'h0, 1'b1); n++; end
        check("t3_pc4", out_pc4, 32'h44);

        // redirect coinciding with an ack
        do_reset();
        wait_min = 0; wait_max = 0;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b1, 32'h103, 1'b1);
        check("t4_empty", 32'(out_valid), 32'h0);
        check("t4_idle", 32'(mem_req), 32'h0);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_req", 32'(mem_req), 32'h1);
        check("t4_addr", mem_addr, 32'h100);

        // simultaneous push and pop at count 3
        do_reset();
        wait_min = 0; wait_max = 0;
        n = 0;
        while (mq.size() < 3 && n < 10) begin tick(1'b1, 1'b0, 32'h0, 1'b0); n++; end
        exp_pc4 = 32'h4;
        for (int k = 0; k < 6; k++) begin
            check("t5_pc4_seq", out_pc4, exp_pc4);
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            exp_pc4 = exp_pc4 + 32'd4;
        end
        check("t5_model_count", mq.size(), 32'h3);

        // reset pulse during discard
        do_reset();
        wait_min = 3; wait_max = 3;
        wait_addr("t6_first", 32'h0, 1'b1, 5);
        tick(1'b1, 1'b1, 32'h200, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        check("t6_req", 32'(mem_req), 32'h0);
        check("t6_addr", mem_addr, 32'h0);
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_inst", out_inst, 32'h0);
        check("t6_pc4", out_pc4, 32'h0);
        wait_addr("t6_restart", 32'h0, 1'b1, 5);

        // randomised traffic
        wait_min = 0; wait_max = 3;
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(399, 0) != 0, $urandom_range(19, 0) == 0, $urandom,
                 $urandom_range(1, 0) == 1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
